// File: rtl/crypto1_pair_join.sv
// Crypto1 even/odd list joiner: buffers two half-state candidate lists and streams
// every even x odd pair as an interleaved 2W-bit LFSR state candidate.
module crypto1_pair_join #(
    parameter int DEPTH = 16,
    parameter int W     = 24
) (
    input  logic           CLK,
    input  logic           RESETn,
    input  logic           E_VALID,
    output logic           E_READY,
    input  logic [W-1:0]   E_DATA,
    input  logic           E_LAST,
    input  logic           E_EMPTY,
    input  logic           O_VALID,
    output logic           O_READY,
    input  logic [W-1:0]   O_DATA,
    input  logic           O_LAST,
    input  logic           O_EMPTY,
    output logic           K_VALID,
    input  logic           K_READY,
    output logic [2*W-1:0] K_DATA,
    output logic           K_LAST,
    output logic           DONE,
    output logic           BUSY
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW-1:0] CAP = CW'(DEPTH);

    localparam logic [1:0] LOAD = 2'd0;
    localparam logic [1:0] PAIR = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]     state, state_next;
    logic [W-1:0]   e_mem [DEPTH];
    logic [W-1:0]   o_mem [DEPTH];
    logic [CW-1:0]  ecnt, ocnt, ecnt_next, ocnt_next;
    logic [CW-1:0]  ei, oi;
    logic           e_done, o_done, e_done_next, o_done_next;
    logic           e_ready, o_ready, e_ready_next, o_ready_next;
    logic           e_acc, o_acc, e_emp, o_emp;
    logic           k_valid, k_last, done, busy;
    logic [2*W-1:0] k_data;
    logic           k_fire, k_load, pair_last, oi_wrap;

    function automatic logic [2*W-1:0] interleave(input logic [W-1:0] e, input logic [W-1:0] o);
        logic [2*W-1:0] k;
        k = '0;
        for (int i = 0; i < W; i++) begin
            k[2*i]   = e[i];
            k[2*i+1] = o[i];
        end
        return k;
    endfunction

    // An EMPTY pulse wins over a data beat on the same side: the list is closed with no entries.
    always_comb begin
        e_acc     = (state == LOAD) && e_ready && E_VALID && !E_EMPTY;
        o_acc     = (state == LOAD) && o_ready && O_VALID && !O_EMPTY;
        e_emp     = (state == LOAD) && !e_done && E_EMPTY;
        o_emp     = (state == LOAD) && !o_done && O_EMPTY;
        k_fire    = k_valid && K_READY;
        k_load    = !k_valid || K_READY;
        oi_wrap   = (oi == ocnt - ONE);
        pair_last = (ei == ecnt - ONE) && oi_wrap;

        state_next = state;
        case (state)
            LOAD:    if (e_done && o_done) state_next = (ecnt == '0 || ocnt == '0) ? FIN : PAIR;
            PAIR:    if (k_fire && k_last) state_next = FIN;
            FIN:     state_next = LOAD;
            default: state_next = LOAD;
        endcase

        if (state == FIN) begin
            ecnt_next   = '0;
            ocnt_next   = '0;
            e_done_next = 1'b0;
            o_done_next = 1'b0;
        end else begin
            ecnt_next   = ecnt + CW'(e_acc);
            ocnt_next   = ocnt + CW'(o_acc);
            e_done_next = e_done || e_emp || (e_acc && E_LAST);
            o_done_next = o_done || o_emp || (o_acc && O_LAST);
        end

        // READY is registered, so it is derived from the values the side will hold next cycle.
        e_ready_next = (state_next == LOAD) && !e_done_next && (ecnt_next < CAP);
        o_ready_next = (state_next == LOAD) && !o_done_next && (ocnt_next < CAP);
    end

    always_ff @(posedge CLK) begin
        if (e_acc) e_mem[ecnt[AW-1:0]] <= E_DATA;
        if (o_acc) o_mem[ocnt[AW-1:0]] <= O_DATA;
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state   <= LOAD;
            ecnt    <= '0;
            ocnt    <= '0;
            e_done  <= 1'b0;
            o_done  <= 1'b0;
            e_ready <= 1'b0;
            o_ready <= 1'b0;
            ei      <= '0;
            oi      <= '0;
            k_valid <= 1'b0;
            k_data  <= '0;
            k_last  <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_next;
            ecnt    <= ecnt_next;
            ocnt    <= ocnt_next;
            e_done  <= e_done_next;
            o_done  <= o_done_next;
            e_ready <= e_ready_next;
            o_ready <= o_ready_next;
            done    <= (state != FIN) && (state_next == FIN);

            if (e_acc || o_acc || e_emp || o_emp)
                busy <= 1'b1;
            else if (state_next == FIN)
                busy <= 1'b0;

            // Pair indices walk even-major; the output register refills whenever it is empty or consumed.
            if (state == LOAD) begin
                ei <= '0;
                oi <= '0;
            end else if (state == PAIR) begin
                if (k_fire && k_last) begin
                    k_valid <= 1'b0;
                    k_last  <= 1'b0;
                end else if (k_load) begin
                    k_valid <= 1'b1;
                    k_data  <= interleave(e_mem[ei[AW-1:0]], o_mem[oi[AW-1:0]]);
                    k_last  <= pair_last;
                    if (oi_wrap) begin
                        oi <= '0;
                        ei <= ei + ONE;
                    end else begin
                        oi <= oi + ONE;
                    end
                end
            end
        end
    end

    assign E_READY = e_ready;
    assign O_READY = o_ready;
    assign K_VALID = k_valid;
    assign K_DATA  = k_data;
    assign K_LAST  = k_last;
    assign DONE    = done;
    assign BUSY    = busy;

endmodule
